// File: rtl/param_regfile_pkg.sv
// Shared helpers for the parametrised register file: byte-lane merge and lane count.
package regfile_pkg;

   localparam int BYTE_W = 8;

   function automatic int num_bytes(input int width);
      return width / BYTE_W;
   endfunction

   // One byte lane of a byte-enabled merge; callers loop over lanes so any WIDTH works.
   function automatic logic [BYTE_W-1:0] be_merge(input logic [BYTE_W-1:0] old_byte,
                                                  input logic [BYTE_W-1:0] new_byte,
                                                  input logic              be);
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/param_regfile_be_register.sv
// One storage word with per-byte write enables and a synchronous active-low clear.
module be_register
   import regfile_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH/8-1:0] be,
   input  logic [WIDTH-1:0]   wr_data,
   output logic [WIDTH-1:0]   word
);

   localparam int BYTES = num_bytes(WIDTH);

   logic [WIDTH-1:0] word_d;
   logic [WIDTH-1:0] word_q;

   always_comb begin
      word_d = word_q;
      for (int k = 0; k < BYTES; k++) begin
         word_d[k*BYTE_W +: BYTE_W] = be_merge(word_q[k*BYTE_W +: BYTE_W],
                                               wr_data[k*BYTE_W +: BYTE_W], be[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) word_q <= '0;
      else        word_q <= word_d;
   end

   assign word = word_q;

endmodule

// File: rtl/param_regfile.sv
// Multi-read, single byte-enabled write register file with hardwired-zero entry and optional bypass.
module param_regfile
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int ZERO_IDX = DEPTH - 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [WIDTH/8-1:0]       wr_be,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*WIDTH-1:0]  rd_data
);

   localparam int BYTES = num_bytes(WIDTH);

   logic [WIDTH-1:0] entry [DEPTH];
   logic             wr_valid;

   // A write that targets the zero entry, an unmapped index or no bytes is a no-op.
   assign wr_valid = wr_en && (|wr_be) && (32'(wr_addr) < DEPTH) && (32'(wr_addr) != ZERO_IDX);

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      if (i == ZERO_IDX) begin : g_zero
         assign entry[i] = '0;
      end else begin : g_reg
         logic [BYTES-1:0] ent_be;
         assign ent_be = (wr_valid && (wr_addr == ADDR_W'(i))) ? wr_be : '0;
         be_register #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .reset   (reset),
            .be      (ent_be),
            .wr_data (wr_data),
            .word    (entry[i])
         );
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      logic [WIDTH-1:0]  word;

      assign idx = rd_addr[p*ADDR_W +: ADDR_W];

      always_comb begin
         word = '0;
         if ((32'(idx) < DEPTH) && (32'(idx) != ZERO_IDX)) begin
            word = entry[idx];
            // Forward the merged write only outside reset; wr_valid already excludes the zero entry.
            if ((BYPASS != 0) && reset && wr_valid && (idx == wr_addr)) begin
               for (int k = 0; k < BYTES; k++) begin
                  word[k*BYTE_W +: BYTE_W] = be_merge(word[k*BYTE_W +: BYTE_W],
                                                      wr_data[k*BYTE_W +: BYTE_W], wr_be[k]);
               end
            end
         end
      end

      assign rd_data[p*WIDTH +: WIDTH] = word;
   end

endmodule

// File: tb/tb_param_regfile.sv
// Directed bench for param_regfile: default config, a no-bypass copy and a 32x20x3 variant.
module tb_param_regfile;

   logic         clk = 1'b0;
   logic         reset;

   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [63:0]  wr_data;
   logic [7:0]   wr_be;
   logic [9:0]   rd_addr;
   logic [127:0] rd_data;
   logic [127:0] rd_data_nb;

   logic         a_wr_en;
   logic [4:0]   a_wr_addr;
   logic [31:0]  a_wr_data;
   logic [3:0]   a_wr_be;
   logic [14:0]  a_rd_addr;
   logic [95:0]  a_rd_data;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   param_regfile dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   param_regfile #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data_nb)
   );

   param_regfile #(.WIDTH(32), .DEPTH(20), .NUM_RD(3), .ZERO_IDX(20)) dut_alt (
      .clk(clk), .reset(reset), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .wr_be(a_wr_be), .rd_addr(a_rd_addr), .rd_data(a_rd_data)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic en, input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
      wr_en = en; wr_addr = a; wr_data = d; wr_be = be;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
      #1;
   endtask

   initial begin
      reset = 1'b0;
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd_addr = '0;
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0; a_rd_addr = '0;
      step();
      reset = 1'b1;

      // preload entry 3 so the reset that follows has something to clear
      wr(1'b1, 5'd3, 64'hA5A5_0000_1234_5678, 8'hFF);
      step();
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd(5'd3, 5'd0);
      chk("preload3", rd_data[63:0], 64'hA5A5_0000_1234_5678);
      chk("reset_idle0", rd_data[127:64], 64'd0);

      // reset wins over a concurrent write
      reset = 1'b0;
      wr(1'b1, 5'd3, {64{1'b1}}, 8'hFF);
      rd(5'd3, 5'd3);
      chk("rst_nobypass", rd_data[63:0], 64'hA5A5_0000_1234_5678);
      step();
      reset = 1'b1;
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd(5'd3, 5'd9);
      chk("rst_e3_p0", rd_data[63:0], 64'd0);
      chk("rst_e9_p1", rd_data[127:64], 64'd0);
      chk("rst_nb_e3", rd_data_nb[63:0], 64'd0);

      // full write
      wr(1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 8'hFF);
      step();
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd(5'd5, 5'd6);
      chk("full_e5", rd_data[63:0], 64'hDEADBEEF_CAFEF00D);
      chk("full_e6", rd_data[127:64], 64'd0);

      // partial write, with same-cycle read showing bypass vs stored value
      wr(1'b1, 5'd5, 64'h11111111_22222222, 8'h0F);
      rd(5'd5, 5'd5);
      chk("part_bypass", rd_data[63:0], 64'hDEADBEEF_22222222);
      chk("part_nb_old", rd_data_nb[63:0], 64'hDEADBEEF_CAFEF00D);
      step();
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd(5'd5, 5'd5);
      chk("part_e5", rd_data[127:64], 64'hDEADBEEF_22222222);

      // zero byte-enable write is ignored
      wr(1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
      rd(5'd5, 5'd0);
      chk("be0_nobypass", rd_data[63:0], 64'hDEADBEEF_22222222);
      step();
      chk("be0_e5", rd_data[63:0], 64'hDEADBEEF_22222222);

      // hardwired-zero entry
      wr(1'b1, 5'd31, 64'h1234, 8'hFF);
      rd(5'd31, 5'd31);
      chk("z31_p0_now", rd_data[63:0], 64'd0);
      chk("z31_p1_now", rd_data[127:64], 64'd0);
      step();
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd(5'd31, 5'd5);
      chk("z31_p0_later", rd_data[63:0], 64'd0);
      chk("z31_e5_same", rd_data[127:64], 64'hDEADBEEF_22222222);

      // bypass on both ports vs no-bypass copy
      wr(1'b1, 5'd7, 64'hAB, 8'h01);
      rd(5'd7, 5'd7);
      chk("byp_p0", rd_data[63:0], 64'hAB);
      chk("byp_p1", rd_data[127:64], 64'hAB);
      chk("nb_p0_old", rd_data_nb[63:0], 64'd0);
      chk("nb_p1_old", rd_data_nb[127:64], 64'd0);
      step();
      wr(1'b0, 5'd0, 64'd0, 8'h00);
      rd(5'd7, 5'd7);
      chk("nb_p0_new", rd_data_nb[63:0], 64'hAB);
      chk("nb_p1_new", rd_data_nb[127:64], 64'hAB);

      // 32-bit, 20-entry, 3-port variant with no zero entry
      a_wr_en = 1'b1; a_wr_addr = 5'd19; a_wr_data = 32'h5A5A5A5A; a_wr_be = 4'hF;
      a_rd_addr = {5'd0, 5'd0, 5'd19};
      #1;
      chk("alt_byp19", 64'(a_rd_data[31:0]), 64'h5A5A5A5A);
      step();
      a_wr_en = 1'b0;
      a_rd_addr = {5'd0, 5'd19, 5'd25};
      #1;
      chk("alt_p0_25", 64'(a_rd_data[31:0]), 64'd0);
      chk("alt_p1_19", 64'(a_rd_data[63:32]), 64'h5A5A5A5A);
      chk("alt_p2_0", 64'(a_rd_data[95:64]), 64'd0);
      a_wr_en = 1'b1; a_wr_addr = 5'd25; a_wr_data = 32'hFFFFFFFF; a_wr_be = 4'hF;
      a_rd_addr = {5'd25, 5'd19, 5'd0};
      #1;
      chk("alt_w25_nobyp", 64'(a_rd_data[95:64]), 64'd0);
      step();
      a_wr_en = 1'b0;
      #1;
      chk("alt_w25_p0", 64'(a_rd_data[31:0]), 64'd0);
      chk("alt_w25_p1", 64'(a_rd_data[63:32]), 64'h5A5A5A5A);
      chk("alt_w25_p2", 64'(a_rd_data[95:64]), 64'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised multi-port register file; next generation of the single enable register.
- Provides DEPTH entries of WIDTH bits, NUM_RD combinational read ports and one synchronous write port with byte enables.
- Has a hardwired-zero entry, optional write-to-read bypass and synchronous clear.
- Sits in the decode stage of the ARM pipeline as the architectural GPR file. Defaults give X0–X30 plus XZR as entry 31.

Parameters:
- WIDTH, 64, entry width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; must be 2 or more.
- ADDR_W, $clog2(DEPTH), address width.
- NUM_RD, 2, number of read ports; must be 1 or more.
- ZERO_IDX, DEPTH-1, index of the hardwired-zero entry. Setting it to DEPTH disables the zero entry.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  WIDTH  write data.
- wr_be  input  WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k].
- rd_addr  input  NUM_RD*ADDR_W  packed read indices; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*WIDTH  packed read data; port p uses bits [p*WIDTH +: WIDTH].

Behaviour:
- Reset: on posedge clk with reset==0, every entry becomes 0. Any write presented in that cycle is discarded. After reset, every rd_data reads 0 in every port.
- Write: on posedge clk with reset==1 and wr_en==1:
  - For each byte k with wr_be[k]==1, entry[wr_addr] byte k takes wr_data byte k.
  - Bytes with wr_be[k]==0 keep their old value.
  - Write latency is 1 cycle; the value is visible from the stored array on the next cycle.
- Ignored writes (no state change, no error):
  - wr_addr==ZERO_IDX.
  - wr_addr>=DEPTH (possible when DEPTH is not a power of 2).
  - wr_be==0.
- Read: purely combinational, zero latency. rd_data[p] = entry[rd_addr[p]], with two exceptions that both return 0:
  - rd_addr[p]==ZERO_IDX.
  - rd_addr[p]>=DEPTH.
- Bypass (BYPASS==1): a read port p returns the post-write merged value instead of the stored entry when all of the following hold:
  - reset==1;
  - wr_en==1;
  - wr_addr==rd_addr[p];
  - the write is not ignored.
  - The merged value is wr_data bytes where wr_be==1, stored bytes elsewhere.
- Bypass is per port. Several ports hitting the same address all see the bypassed value.
- While reset==0 the bypass is suppressed and reads return stored contents.
- BYPASS==0: reads always return stored contents. Same-cycle read-after-write sees the old value.
- Read-only ports never alter state. There is no read/write hazard beyond the bypass rule above.
- Reset asserted mid-sequence takes priority over any concurrent write. There is no partial update.
- No X propagation: every rd_data bit is driven for every address value.

Decomposition:
- Shared package regfile_pkg:
  - function be_merge(old, new, be) returning the byte-merged word, used by both the write path and the bypass path.
  - localparam BYTES = WIDTH/8 helper.
- One sub-module, be_register:
  - WIDTH-bit storage word with per-byte enable and synchronous active-low clear.
  - Same clk/reset naming.
  - param_regfile instantiates DEPTH-1 of them, skipping ZERO_IDX, in a generate loop.
- Read muxing and bypass compare stay in param_regfile.

Test Plan:
1. Reset with wr_en=1, wr_addr=3, wr_data=all ones asserted in the same cycle -> after the edge every rd_data==0 and entry 3 reads 0.
2. Write entry 5 = 64'hDEADBEEF_CAFEF00D with wr_be=8'hFF. Next cycle rd_addr0=5 -> rd_data0==64'hDEADBEEF_CAFEF00D; rd_addr1=6 -> 0.
3. Partial write to entry 5 with wr_be=8'h0F, wr_data=64'h11111111_22222222 -> entry 5 reads 64'hDEADBEEF_22222222.
4. Write to ZERO_IDX (31) = 64'h1234 -> both ports reading 31 return 0, that cycle and later; no other entry changes.
5. BYPASS=1: with entry 7=0, in the same cycle wr_en=1, wr_addr=7, wr_be=8'h01, wr_data=64'hAB and rd_addr0=rd_addr1=7 -> both ports read 64'hAB before the edge. Repeat with BYPASS=0 -> both read 0 that cycle and 64'hAB the next.
6. Alternate config WIDTH=32, DEPTH=20, NUM_RD=3: write entry 19=32'h5A5A5A5A -> a port reading 19 returns it; any port with rd_addr=25 returns 0; a write to address 25 changes nothing.
